// File: rtl/simmem_pkg.sv
// Shared types and constants for the simulated-memory read path.
// The rdata responder adds its state enum, FIFO depth and beat helpers here.
package simmem_pkg;

  localparam int unsigned IDWidth             = 4;
  localparam int unsigned AddrWidth           = 16;
  localparam int unsigned BurstLenWidth       = 8;
  localparam int unsigned XDataWidth          = 32;
  localparam int unsigned WStrbWidth          = XDataWidth / 8;
  localparam int unsigned MaxReadDataBurstLen = 4;
  localparam int unsigned DelayWidth          = 4;
  localparam int unsigned BeatCntWidth        = $clog2(MaxReadDataBurstLen);

  localparam int unsigned RdataResponderFifoDepth = 4;
  localparam logic [WStrbWidth-1:0] RespOkay = {WStrbWidth{1'b0}};

  typedef struct packed {
    logic [IDWidth-1:0]       id;
    logic [AddrWidth-1:0]     addr;
    logic [BurstLenWidth-1:0] burst_length;
  } raddr_req_t;

  typedef struct packed {
    logic [IDWidth-1:0]    id;
    logic [XDataWidth-1:0] data;
    logic [WStrbWidth-1:0] response;
    logic                  last;
  } rdata_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } rdata_responder_state_e;

  // Index of the final beat: burst_length clamped to the longest supported burst.
  function automatic logic [BeatCntWidth-1:0] last_beat_idx(input logic [BurstLenWidth-1:0] len);
    logic [BurstLenWidth-1:0] cap;
    logic [BeatCntWidth-1:0]  idx;
    cap = BurstLenWidth'(MaxReadDataBurstLen - 1);
    if (len >= cap) begin
      idx = BeatCntWidth'(MaxReadDataBurstLen - 1);
    end else begin
      idx = len[BeatCntWidth-1:0];
    end
    return idx;
  endfunction

  function automatic rdata_t make_beat(input raddr_req_t req,
                                       input logic [BeatCntWidth-1:0] idx,
                                       input logic last);
    rdata_t beat;
    beat.id       = req.id;
    beat.data     = XDataWidth'(req.addr) + XDataWidth'(idx);
    beat.response = RespOkay;
    beat.last     = last;
    return beat;
  endfunction

endpackage

// File: rtl/simmem_rdata_responder_if.sv
// Read-address request and read-data beat channels of the rdata responder.
// The slave modport is the responder's view; master is the requester/consumer view.
interface simmem_rdata_responder_if;
  import simmem_pkg::*;

  logic       raddr_in_valid_i;
  logic       raddr_in_ready_o;
  raddr_req_t raddr_in_i;
  logic       rdata_out_valid_o;
  logic       rdata_out_ready_i;
  rdata_t     rdata_out_o;

  modport slave (
    input  raddr_in_valid_i,
    input  raddr_in_i,
    input  rdata_out_ready_i,
    output raddr_in_ready_o,
    output rdata_out_valid_o,
    output rdata_out_o
  );

  modport master (
    output raddr_in_valid_i,
    output raddr_in_i,
    output rdata_out_ready_i,
    input  raddr_in_ready_o,
    input  rdata_out_valid_o,
    input  rdata_out_o
  );

endinterface

// File: rtl/simmem_req_fifo.sv
// Generic synchronous FIFO; pointers carry an extra MSB so full and empty
// are distinguished without a separate occupancy counter.
module simmem_req_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);
  localparam logic [PtrWidth:0] PtrOne = {{PtrWidth{1'b0}}, 1'b1};

  logic [PtrWidth:0] wr_ptr_r;
  logic [PtrWidth:0] rd_ptr_r;
  logic [Width-1:0]  mem_r [Depth];
  logic              push_s;
  logic              pop_s;

  assign full_o  = (wr_ptr_r[PtrWidth] != rd_ptr_r[PtrWidth]) &&
                   (wr_ptr_r[PtrWidth-1:0] == rd_ptr_r[PtrWidth-1:0]);
  assign empty_o = (wr_ptr_r == rd_ptr_r);
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign data_o  = mem_r[rd_ptr_r[PtrWidth-1:0]];

  // Read/write pointer advance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {(PtrWidth+1){1'b0}};
      rd_ptr_r <= {(PtrWidth+1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PtrOne;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PtrOne;
      end
    end
  end

  // Entry storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_r[i] <= {Width{1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r[PtrWidth-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/simmem_rdata_responder.sv
// Memory-side read responder: queues read-address requests and answers each,
// in order, with a read-data burst after a fixed latency.
module simmem_rdata_responder
  import simmem_pkg::*;
#(
  parameter int unsigned FifoDepth       = RdataResponderFifoDepth,
  parameter int unsigned ResponseLatency = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  simmem_rdata_responder_if.slave  bus
);

  localparam logic [DelayWidth-1:0]   LatLoad  = DelayWidth'(ResponseLatency);
  localparam logic [DelayWidth-1:0]   LatOne   = {{(DelayWidth-1){1'b0}}, 1'b1};
  localparam logic [BeatCntWidth-1:0] BeatZero = {BeatCntWidth{1'b0}};
  localparam logic [BeatCntWidth-1:0] BeatOne  = {{(BeatCntWidth-1){1'b0}}, 1'b1};

  rdata_responder_state_e  state_r;
  raddr_req_t              cur_req_r;
  raddr_req_t              fifo_head_s;
  logic [DelayWidth-1:0]   lat_cnt_r;
  logic [BeatCntWidth-1:0] beat_cnt_r;
  logic [BeatCntWidth-1:0] last_idx_s;
  logic [BeatCntWidth-1:0] next_beat_s;
  logic                    fifo_full_s;
  logic                    fifo_empty_s;
  logic                    fifo_pop_s;
  logic                    handshake_s;
  logic                    out_valid_r;
  rdata_t                  out_data_r;

  assign fifo_pop_s  = (state_r == IDLE) && !fifo_empty_s;
  assign handshake_s = out_valid_r && bus.rdata_out_ready_i;
  assign last_idx_s  = last_beat_idx(cur_req_r.burst_length);
  assign next_beat_s = beat_cnt_r + BeatOne;

  simmem_req_fifo #(
    .Width ($bits(raddr_req_t)),
    .Depth (FifoDepth)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (bus.raddr_in_valid_i),
    .data_i  (bus.raddr_in_i),
    .pop_i   (fifo_pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign bus.raddr_in_ready_o  = !fifo_full_s;
  assign bus.rdata_out_valid_o = out_valid_r;
  assign bus.rdata_out_o       = out_data_r;

  // Response FSM; the output beat is registered and only changes on entry to
  // BURST or on a handshake, so it is stable under backpressure.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      cur_req_r   <= '{default: '0};
      lat_cnt_r   <= {DelayWidth{1'b0}};
      beat_cnt_r  <= BeatZero;
      out_valid_r <= 1'b0;
      out_data_r  <= '{default: '0};
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s) begin
            cur_req_r  <= fifo_head_s;
            lat_cnt_r  <= LatLoad;
            beat_cnt_r <= BeatZero;
            if (ResponseLatency == 0) begin
              state_r     <= BURST;
              out_valid_r <= 1'b1;
              out_data_r  <= make_beat(fifo_head_s, BeatZero,
                                       last_beat_idx(fifo_head_s.burst_length) == BeatZero);
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (lat_cnt_r <= LatOne) begin
            state_r     <= BURST;
            out_valid_r <= 1'b1;
            out_data_r  <= make_beat(cur_req_r, beat_cnt_r, beat_cnt_r == last_idx_s);
          end else begin
            lat_cnt_r <= lat_cnt_r - LatOne;
          end
        end
        BURST: begin
          if (handshake_s) begin
            if (beat_cnt_r == last_idx_s) begin
              state_r     <= IDLE;
              out_valid_r <= 1'b0;
              out_data_r  <= '{default: '0};
            end else begin
              beat_cnt_r <= next_beat_s;
              out_data_r <= make_beat(cur_req_r, next_beat_s, next_beat_s == last_idx_s);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          out_data_r  <= '{default: '0};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simmem_rdata_responder.sv
// Directed bench for simmem_rdata_responder with hand-computed beats.
module tb_simmem_rdata_responder;
  import simmem_pkg::*;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  simmem_rdata_responder_if bus ();

  simmem_rdata_responder #(
    .FifoDepth       (4),
    .ResponseLatency (2)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic rdata_t beat(input logic [IDWidth-1:0] id,
                                  input logic [XDataWidth-1:0] data, input logic last);
    rdata_t b;
    b.id       = id;
    b.data     = data;
    b.response = {WStrbWidth{1'b0}};
    b.last     = last;
    return b;
  endfunction

  function automatic raddr_req_t req(input logic [IDWidth-1:0] id,
                                     input logic [AddrWidth-1:0] addr,
                                     input logic [BurstLenWidth-1:0] len);
    raddr_req_t r;
    r.id           = id;
    r.addr         = addr;
    r.burst_length = len;
    return r;
  endfunction

  task automatic send_req(input raddr_req_t r);
    int n = 0;
    bus.raddr_in_valid_i = 1'b1;
    bus.raddr_in_i       = r;
    while (!bus.raddr_in_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 100) check_val("send_timeout", 64'(n), 64'd0);
    @(negedge clk_i);
    bus.raddr_in_valid_i = 1'b0;
  endtask

  task automatic check_beat(input string tag, input rdata_t exp);
    check_val({tag, "_valid"}, 64'(bus.rdata_out_valid_o), 64'd1);
    check_val(tag, 64'(bus.rdata_out_o), 64'(exp));
  endtask

  // Waits for a beat, checks it and lets it handshake (ready assumed high).
  task automatic expect_beat(input string tag, input rdata_t exp);
    int n = 0;
    while (!bus.rdata_out_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check_beat(tag, exp);
    @(negedge clk_i);
  endtask

  initial begin
    raddr_req_t q[$];
    raddr_req_t r;
    int acc;
    int seen;
    int nb;

    bus.raddr_in_valid_i  = 1'b0;
    bus.raddr_in_i        = '{default: '0};
    bus.rdata_out_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check_val("rst_valid", 64'(bus.rdata_out_valid_o), 64'd0);
    check_val("rst_ready", 64'(bus.raddr_in_ready_o), 64'd1);
    check_val("rst_data", 64'(bus.rdata_out_o), 64'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Single request accepted in cycle 0: beats in cycles 4,5,6.
    send_req(req(4'd3, 16'h0010, 8'd2));
    for (int c = 1; c < 4; c++) begin
      check_val($sformatf("lat_c%0d", c), 64'(bus.rdata_out_valid_o), 64'd0);
      @(negedge clk_i);
    end
    check_beat("single_b0", beat(4'd3, 32'h10, 1'b0));
    @(negedge clk_i);
    check_beat("single_b1", beat(4'd3, 32'h11, 1'b0));
    @(negedge clk_i);
    check_beat("single_b2", beat(4'd3, 32'h12, 1'b1));
    @(negedge clk_i);
    check_val("single_done_valid", 64'(bus.rdata_out_valid_o), 64'd0);
    check_val("single_done_data", 64'(bus.rdata_out_o), 64'd0);

    // Clamp to four beats, then a one-beat burst.
    send_req(req(4'd5, 16'h0020, 8'd7));
    expect_beat("clamp_b0", beat(4'd5, 32'h20, 1'b0));
    expect_beat("clamp_b1", beat(4'd5, 32'h21, 1'b0));
    expect_beat("clamp_b2", beat(4'd5, 32'h22, 1'b0));
    expect_beat("clamp_b3", beat(4'd5, 32'h23, 1'b1));
    check_val("clamp_after", 64'(bus.rdata_out_valid_o), 64'd0);
    send_req(req(4'd6, 16'h0040, 8'd0));
    expect_beat("len0_b0", beat(4'd6, 32'h40, 1'b1));

    // Backpressure on the second beat.
    send_req(req(4'd7, 16'h0010, 8'd2));
    expect_beat("bp_b0", beat(4'd7, 32'h10, 1'b0));
    bus.rdata_out_ready_i = 1'b0;
    repeat (5) begin
      check_beat("bp_hold", beat(4'd7, 32'h11, 1'b0));
      @(negedge clk_i);
    end
    bus.rdata_out_ready_i = 1'b1;
    expect_beat("bp_b1", beat(4'd7, 32'h11, 1'b0));
    expect_beat("bp_b2", beat(4'd7, 32'h12, 1'b1));

    // Data arithmetic carries past 8 bits.
    send_req(req(4'd2, 16'h00FF, 8'd1));
    expect_beat("arith_b0", beat(4'd2, 32'hFF, 1'b0));
    expect_beat("arith_b1", beat(4'd2, 32'h100, 1'b1));

    // Fill the FIFO while the first burst is stalled.
    bus.rdata_out_ready_i = 1'b0;
    acc = 0;
    for (int k = 0; k < 7; k++) begin
      r = req(IDWidth'(k + 1), AddrWidth'(16'h0080 + 16 * k), BurstLenWidth'(k % 3));
      bus.raddr_in_valid_i = 1'b1;
      bus.raddr_in_i       = r;
      if (bus.raddr_in_ready_o) begin
        acc++;
        q.push_back(r);
      end
      @(negedge clk_i);
    end
    bus.raddr_in_valid_i = 1'b0;
    check_val("full_accepted", 64'(acc), 64'd5);
    check_val("full_ready", 64'(bus.raddr_in_ready_o), 64'd0);

    bus.rdata_out_ready_i = 1'b1;
    r = q.pop_front();
    expect_beat("drain_a", beat(4'd1, 32'h80, 1'b1));
    check_val("ready_bubble", 64'(bus.raddr_in_ready_o), 64'd0);
    @(negedge clk_i);
    check_val("ready_freed", 64'(bus.raddr_in_ready_o), 64'd1);
    while (q.size() > 0) begin
      r  = q.pop_front();
      nb = (r.burst_length >= 8'd3) ? 4 : int'(r.burst_length) + 1;
      for (int i = 0; i < nb; i++) begin
        expect_beat($sformatf("drain_id%0d_b%0d", r.id, i),
                    beat(r.id, 32'(r.addr) + 32'(i), i == nb - 1));
      end
    end

    // Asynchronous reset during a burst with two requests queued.
    bus.rdata_out_ready_i = 1'b0;
    send_req(req(4'd10, 16'h0200, 8'd3));
    send_req(req(4'd11, 16'h0300, 8'd1));
    send_req(req(4'd12, 16'h0400, 8'd0));
    for (int n = 0; n < 20 && !bus.rdata_out_valid_o; n++) @(negedge clk_i);
    check_beat("rst_pre", beat(4'd10, 32'h200, 1'b0));
    #2 rst_ni = 1'b0;
    #1;
    check_val("rst_mid_valid", 64'(bus.rdata_out_valid_o), 64'd0);
    check_val("rst_mid_ready", 64'(bus.raddr_in_ready_o), 64'd1);
    check_val("rst_mid_data", 64'(bus.rdata_out_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    bus.rdata_out_ready_i = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk_i);
      if (bus.rdata_out_valid_o) seen++;
    end
    check_val("rst_no_beats", 64'(seen), 64'd0);
    send_req(req(4'd9, 16'h0500, 8'd0));
    expect_beat("post_rst", beat(4'd9, 32'h500, 1'b1));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/simmem_rdata_responder.md
Name: simmem_rdata_responder

Overview:
- Memory-side responder for the simulated-memory read path.
- Accepts AXI read-address requests (raddr_req_t) and returns read-data bursts (rdata_t) after a fixed latency.
- Acts as the downstream slave that feeds the read data bank, so the bank can be exercised end to end without a real memory model.
- Holds up to FifoDepth pending requests and serves them strictly in order.

Parameters:
- FifoDepth, 4: number of request FIFO entries; power of two, at least 2.
- ResponseLatency, 2: idle cycles between popping a request and presenting its first beat; range 0..(2**DelayWidth)-1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- raddr_in_valid_i  in  1  read-address request valid
- raddr_in_ready_o  out  1  responder can accept a request
- raddr_in_i  in  $bits(raddr_req_t)  read-address request
- rdata_out_valid_o  out  1  read-data beat valid
- rdata_out_ready_i  in  1  downstream accepts the beat
- rdata_out_o  out  $bits(rdata_t)  read-data beat

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - Assertion immediately clears FIFO, FSM (to IDLE), latency counter and beat counter.
  - Outputs during and after reset: rdata_out_valid_o=0, rdata_out_o=0, raddr_in_ready_o=1.
- Request side:
  - raddr_in_ready_o = !fifo_full, registered-state based; no combinational path from any input.
  - A push and a pop in the same cycle while full is not accepted: ready stays low that cycle.
  - A push into an empty FIFO is not visible to the FSM until the next cycle.
- FSM states:
  - IDLE: if FIFO not empty, pop head into the current-request register, load latency counter with ResponseLatency, clear beat counter. Go to WAIT if ResponseLatency>0, otherwise go to BURST.
  - WAIT: decrement counter each cycle; go to BURST when the counter reaches 1.
  - BURST: rdata_out_valid_o=1. On handshake: if the beat is the last, go to IDLE; otherwise increment the beat counter.
- Latency:
  - Request accepted in cycle t, with the FIFO empty and the FSM in IDLE: first beat valid in cycle t+2+ResponseLatency.
  - After each burst there is exactly one IDLE bubble cycle before the next request is popped.
- Beat count: beats = min(burst_length+1, MaxReadDataBurstLen). All arithmetic is unsigned.
  - burst_length=0 gives 1 beat.
  - burst_length>=3 is clamped to 4 beats.
  - Beat counter width is $clog2(MaxReadDataBurstLen).
- Beat contents:
  - data = zero-extend(addr) to XDataWidth, plus beat index, modulo 2**XDataWidth.
  - id = request id.
  - response = RespOkay (0).
  - last = 1 only on the final beat.
- AXI stability: while valid is high and ready is low, rdata_out_o and valid are held unchanged.
- Outside BURST: rdata_out_valid_o=0 and rdata_out_o=0.
- Ordering: responses are in request order regardless of id.
- Reset mid-burst: valid drops asynchronously; pending requests are discarded.

Decomposition:
- Add to simmem_pkg:
  - RespOkay localparam (0, width WStrbWidth, matching the rdata response field).
  - RdataResponderFifoDepth=4.
  - rdata_responder_state_e enum {IDLE, WAIT, BURST}.
- Reuse from simmem_pkg: raddr_req_t, rdata_t, MaxReadDataBurstLen, DelayWidth.
- One sub-module: simmem_req_fifo. It is a generic synchronous FIFO, parameterised on width and depth, with full/empty flags and pointer wrap via an extra MSB.

Test Plan:
- Single request: ResponseLatency=2, accept {id=3, addr=0x10, len=2} in cycle 0, rdata_out_ready_i=1.
  - Expect beats in cycles 4, 5, 6 with data 0x10, 0x11, 0x12, id=3, response=0, last=0/0/1.
  - Then valid low and FSM in IDLE.
- Clamp and length 0: {id=5, addr=0x20, len=7} gives 4 beats 0x20..0x23, last on the 4th. {id=6, addr=0x40, len=0} gives 1 beat 0x40 with last=1.
- Backpressure: during beat 2 of a 3-beat burst, hold rdata_out_ready_i=0 for 5 cycles.
  - Expect valid=1 and data=0x11 held stable the whole time.
  - Release gives 0x11 then 0x12 with last=1.
- Full FIFO: rdata_out_ready_i=0, offer 7 consecutive requests.
  - Expect 5 accepted (1 popped + 4 in FIFO), after which raddr_in_ready_o=0.
  - Drain: all 5 bursts return in order with correct ids; ready returns to 1 the cycle after the first pop frees a slot.
- Data arithmetic: addr=0xFF, len=1 gives data 0xFF, then 0x100, with no truncation to 8 bits.
- Reset mid-burst: assert rst_ni=0 asynchronously on beat 1 with 2 requests queued.
  - Expect valid=0 and ready=1 immediately.
  - After release, no beats appear until a new request is accepted.
